kronos_keccak_state_ctrl: RTL and testbench



---
 rtl/kronos_keccak_state_ctrl.sv | 148 ++++++++++++++
 tb/tb_kronos_keccak_state_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_keccak_state_ctrl.sv
// Word-addressed state holder and launch sequencer for the Keccak-f[1600] core.
// Optional sponge-absorb writes (XOR into state) with KRONOS_KECCAK_ABSORB_XOR_EN.
//
// state  | meaning
// IDLE   | state writable/readable, waiting for start
// LAUNCH | core_start_o pulsed, state presented to the core
// BUSY   | waiting for core_done_i to capture the result
// DRAIN  | aborted by clear; waiting for core_done_i, result discarded
module kronos_keccak_state_ctrl #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_valid_i,
   input  logic [IDX_W-1:0]     wr_idx_i,
   input  logic [WORD_W-1:0]    wr_data_i,
   output logic                 wr_ready_o,
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
   input  logic                 absorb_bypass_i,
`endif
   input  logic                 rd_valid_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   output logic                 rd_valid_o,
   output logic [WORD_W-1:0]    rd_data_o,
   output logic                 rd_err_o,
   input  logic                 start_i,
   input  logic                 clear_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 core_start_o,
   output logic [1599:0]        core_din_o,
   input  logic [1599:0]        core_dout_i,
   input  logic                 core_done_i
);

   localparam int NWORDS = 1600 / WORD_W;

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("kronos_keccak_state_ctrl: WORD_W must be 32 or 64");
   end
   if ((2 ** IDX_W) < NWORDS) begin : g_bad_idx_w
      $error("kronos_keccak_state_ctrl: IDX_W too narrow for NWORDS");
   end

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_BUSY   = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]                    r_fsm;
   logic [NWORDS-1:0][WORD_W-1:0] r_state;
   logic                          r_rd_valid;
   logic [WORD_W-1:0]             r_rd_data;
   logic                          r_rd_err;

   logic                          w_busy;
   logic                          w_wr_en;
   logic                          w_rd_idx_ok;
   logic [WORD_W-1:0]             w_rd_word;
   logic [WORD_W-1:0]             w_wr_old;
   logic [WORD_W-1:0]             w_wr_word;

   assign w_busy      = (r_fsm != ST_IDLE);
   assign w_rd_idx_ok = (rd_idx_i < IDX_W'(NWORDS));
   assign w_wr_en     = wr_valid_i && (r_fsm == ST_IDLE) && (wr_idx_i < IDX_W'(NWORDS));

   always_comb begin
      w_rd_word = '0;
      w_wr_old  = '0;
      for (int i = 0; i < NWORDS; i++) begin
         if (rd_idx_i == IDX_W'(i)) w_rd_word = r_state[i];
         if (wr_idx_i == IDX_W'(i)) w_wr_old  = r_state[i];
      end
   end

`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
   assign w_wr_word = absorb_bypass_i ? wr_data_i : (w_wr_old ^ wr_data_i);
`else
   assign w_wr_word = wr_data_i;
   logic w_unused_old;
   assign w_unused_old = ^w_wr_old;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fsm   <= ST_IDLE;
         r_state <= '0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               // clear wins over a same-cycle write and start
               if (clear_i) begin
                  r_state <= '0;
               end else begin
                  for (int i = 0; i < NWORDS; i++) begin
                     if (w_wr_en && (wr_idx_i == IDX_W'(i))) r_state[i] <= w_wr_word;
                  end
                  if (start_i) r_fsm <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (clear_i) begin
                  r_state <= '0;
                  r_fsm   <= ST_DRAIN;
               end else begin
                  r_fsm <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // a clear coinciding with core completion has nothing left to drain
               if (clear_i) begin
                  r_state <= '0;
                  r_fsm   <= core_done_i ? ST_IDLE : ST_DRAIN;
               end else if (core_done_i) begin
                  r_state <= core_dout_i;
                  r_fsm   <= ST_IDLE;
               end
            end
            default: begin
               if (core_done_i) r_fsm <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= rd_valid_i;
         r_rd_err   <= rd_valid_i && (!w_rd_idx_ok || w_busy);
         r_rd_data  <= (rd_valid_i && w_rd_idx_ok && !w_busy) ? w_rd_word : '0;
      end
   end

   assign wr_ready_o   = (r_fsm == ST_IDLE);
   assign busy_o       = w_busy;
   assign core_start_o = (r_fsm == ST_LAUNCH);
   assign done_o       = (r_fsm == ST_BUSY) && core_done_i && !clear_i;
   assign core_din_o   = r_state;
   assign rd_valid_o   = r_rd_valid;
   assign rd_data_o    = r_rd_data;
   assign rd_err_o     = r_rd_err;

endmodule

// File: tb/tb_kronos_keccak_state_ctrl.sv
// Directed bench for kronos_keccak_state_ctrl: word-array reference model plus literal checks.
module tb_kronos_keccak_state_ctrl;

`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
   localparam int WW = 64;
`else
   localparam int WW = 32;
`endif
   localparam int NW = 1600 / WW;
   localparam int IW = 6;

   logic            clk, rst_n;
   logic            wr_valid_i, rd_valid_i, start_i, clear_i, core_done_i;
   logic [IW-1:0]   wr_idx_i, rd_idx_i;
   logic [WW-1:0]   wr_data_i;
   logic            wr_ready_o, rd_valid_o, rd_err_o, busy_o, done_o, core_start_o;
   logic [WW-1:0]   rd_data_o;
   logic [1599:0]   core_din_o, core_dout_i;
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
   logic            absorb_bypass_i;
`endif

   kronos_keccak_state_ctrl #(.WORD_W(WW), .IDX_W(IW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_valid_i(wr_valid_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
      .absorb_bypass_i(absorb_bypass_i),
`endif
      .rd_valid_i(rd_valid_i), .rd_idx_i(rd_idx_i), .rd_valid_o(rd_valid_o),
      .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
      .start_i(start_i), .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o),
      .core_start_o(core_start_o), .core_din_o(core_din_o),
      .core_dout_i(core_dout_i), .core_done_i(core_done_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start  = 0;
   int n_done   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_din(input string name, input logic [1599:0] act, input logic [1599:0] exp);
      int bad;
      n_checks++;
      if (act === exp) n_pass++;
      else begin
         bad = 0;
         for (int i = NW - 1; i >= 0; i--) if (act[i*WW +: WW] !== exp[i*WW +: WW]) bad = i;
         $display("FAIL %s: word %0d got %0h expected %0h at %0t", name, bad,
                  act[bad*WW +: WW], exp[bad*WW +: WW], $time);
      end
   endtask

   // Reference model: state as an array of words plus an abstract phase
   // (0 idle, 1 launching, 2 awaiting result, 3 awaiting discarded result).
   logic [WW-1:0] m_mem [NW];
   int            m_phase = 0;
   logic          m_rdv = 1'b0;
   logic [WW-1:0] m_rdd = '0;
   logic          m_rde = 1'b0;

   function automatic logic [1599:0] m_pack();
      logic [1599:0] v;
      v = '0;
      for (int i = 0; i < NW; i++) v[i*WW +: WW] = m_mem[i];
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) m_mem[i] <= '0;
         m_phase <= 0;
         m_rdv   <= 1'b0;
         m_rdd   <= '0;
         m_rde   <= 1'b0;
      end else begin
         m_rdv <= rd_valid_i;
         if (rd_valid_i && int'(rd_idx_i) < NW && m_phase == 0) begin
            m_rdd <= m_mem[int'(rd_idx_i)];
            m_rde <= 1'b0;
         end else begin
            m_rdd <= '0;
            m_rde <= rd_valid_i;
         end
         case (m_phase)
            0: begin
               if (clear_i) begin
                  for (int i = 0; i < NW; i++) m_mem[i] <= '0;
               end else begin
                  if (wr_valid_i && int'(wr_idx_i) < NW) begin
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
                     m_mem[int'(wr_idx_i)] <= absorb_bypass_i ? wr_data_i
                                              : (m_mem[int'(wr_idx_i)] ^ wr_data_i);
`else
                     m_mem[int'(wr_idx_i)] <= wr_data_i;
`endif
                  end
                  if (start_i) m_phase <= 1;
               end
            end
            1: begin
               if (clear_i) begin
                  for (int i = 0; i < NW; i++) m_mem[i] <= '0;
                  m_phase <= 3;
               end else m_phase <= 2;
            end
            2: begin
               if (clear_i) begin
                  for (int i = 0; i < NW; i++) m_mem[i] <= '0;
                  m_phase <= core_done_i ? 0 : 3;
               end else if (core_done_i) begin
                  for (int i = 0; i < NW; i++) m_mem[i] <= core_dout_i[i*WW +: WW];
                  m_phase <= 0;
               end
            end
            default: if (core_done_i) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("m_busy", busy_o, 64'(m_phase != 0));
         chk("m_wr_ready", wr_ready_o, 64'(m_phase == 0));
         chk("m_core_start", core_start_o, 64'(m_phase == 1));
         chk("m_done", done_o, 64'(m_phase == 2 && core_done_i && !clear_i));
         chk("m_rd_valid", rd_valid_o, 64'(m_rdv));
         chk("m_rd_data", 64'(rd_data_o), 64'(m_rdd));
         chk("m_rd_err", rd_err_o, 64'(m_rde));
         chk_din("m_core_din", core_din_o, m_pack());
         if (core_start_o) n_start++;
      end
   end

   always @(posedge clk) if (rst_n && done_o) n_done++;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_write(input int idx, input logic [WW-1:0] d);
      wr_valid_i = 1'b1; wr_idx_i = IW'(idx); wr_data_i = d;
      cyc();
      wr_valid_i = 1'b0;
   endtask

   task automatic do_read(input int idx, output logic [WW-1:0] d, output logic e, output logic v);
      rd_valid_i = 1'b1; rd_idx_i = IW'(idx);
      cyc();
      rd_valid_i = 1'b0;
      d = rd_data_o; e = rd_err_o; v = rd_valid_o;
   endtask

   task automatic finish_core(input logic [1599:0] dout);
      core_dout_i = dout; core_done_i = 1'b1;
      cyc();
      core_done_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [WW-1:0] rd;
   logic          re, rv;
   logic [1599:0] exp_din;
   int            nonzero;

   initial begin
      rst_n = 1'b1;
      wr_valid_i = 0; rd_valid_i = 0; start_i = 0; clear_i = 0; core_done_i = 0;
      wr_idx_i = '0; rd_idx_i = '0; wr_data_i = '0; core_dout_i = '0;
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
      absorb_bypass_i = 1'b0;
`endif
      #2 rst_n = 1'b0;
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_en = 1'b1;

      chk("rst_wr_ready", wr_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_core_start", core_start_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rd_valid", rd_valid_o, 0);
      chk_din("rst_state", core_din_o, '0);

      do_read(0, rd, re, rv);
      chk("rd0_valid", rv, 1); chk("rd0_data", 64'(rd), 0); chk("rd0_err", re, 0);

      do_write(NW - 1, WW'(32'hDEADBEEF));
      do_read(NW - 1, rd, re, rv);
      chk("rd_last_data", 64'(rd), 64'h0000_0000_DEAD_BEEF); chk("rd_last_err", re, 0);
      do_read(NW, rd, re, rv);
      chk("rd_oob_valid", rv, 1); chk("rd_oob_data", 64'(rd), 0); chk("rd_oob_err", re, 1);
      do_write(63, '1);
      exp_din = '0;
      exp_din[(NW-1)*WW +: WW] = WW'(32'hDEADBEEF);
      chk_din("wr_oob_dropped", core_din_o, exp_din);

      // read of a word in the same cycle as its write returns the old value
      wr_valid_i = 1; wr_idx_i = 2; wr_data_i = WW'(8'hAB);
      rd_valid_i = 1; rd_idx_i = 2;
      cyc();
      wr_valid_i = 0; rd_valid_i = 0;
      chk("rd_same_cycle_old", 64'(rd_data_o), 0);
      do_read(2, rd, re, rv);
      chk("rd_after_write", 64'(rd), 64'hAB);

      n_start = 0; n_done = 0;
      wr_valid_i = 1; wr_idx_i = 0; wr_data_i = WW'(1); start_i = 1;
      cyc();
      wr_valid_i = 0; start_i = 0;
      chk("launch_core_start", core_start_o, 1);
      chk("launch_din_word0", 64'(core_din_o[31:0]), 1);
      chk("launch_busy", busy_o, 1);
      chk("launch_wr_ready", wr_ready_o, 0);
      cyc();
      chk("busy_core_start_low", core_start_o, 0);
      repeat (22) cyc();
      core_dout_i = {200{8'hA5}}; core_done_i = 1;
      #1;
      chk("done_pulse", done_o, 1);
      cyc();
      core_done_i = 0;
      chk("done_busy_low", busy_o, 0);
      chk("done_low_after", done_o, 0);
      chk("start_pulses", 64'(n_start), 1);
      chk("done_pulses", 64'(n_done), 1);
      do_read(3, rd, re, rv);
      chk("rd_result", 64'(rd), 64'(WW'({8{8'hA5}})));

      start_i = 1; cyc(); start_i = 0; cyc();
      start_i = 1; wr_valid_i = 1; wr_idx_i = 1; wr_data_i = WW'(8'h77);
      #1;
      chk("busy_wr_ready", wr_ready_o, 0);
      cyc();
      start_i = 0; wr_valid_i = 0;
      chk("busy_write_ignored", 64'(core_din_o[WW +: WW]), 64'(WW'({8{8'hA5}})));
      do_read(1, rd, re, rv);
      chk("busy_rd_err", re, 1); chk("busy_rd_data", 64'(rd), 0);
      finish_core({50{32'h0F1E2D3C}});
      chk("idle_after_2nd", busy_o, 0);
      cyc();
      chk("no_queued_start", busy_o, 0);
      chk("start_pulses_2", 64'(n_start), 2);

      start_i = 1; cyc(); start_i = 0; cyc();
      clear_i = 1; cyc(); clear_i = 0;
      chk("drain_busy", busy_o, 1);
      chk_din("drain_state_zero", core_din_o, '0);
      repeat (5) cyc();
      chk("drain_busy_hold", busy_o, 1);
      core_dout_i = '1; core_done_i = 1;
      #1;
      chk("drain_no_done", done_o, 0);
      cyc();
      core_done_i = 0;
      chk("drain_exit", busy_o, 0);
      chk("done_pulses_2", 64'(n_done), 2);
      nonzero = 0;
      for (int i = 0; i < NW; i++) begin
         do_read(i, rd, re, rv);
         if (rd != '0 || re) nonzero++;
      end
      chk("clear_all_words", 64'(nonzero), 0);

      do_write(5, WW'(8'h55));
      clear_i = 1; wr_valid_i = 1; wr_idx_i = 6; wr_data_i = WW'(8'h66); start_i = 1;
      cyc();
      clear_i = 0; wr_valid_i = 0; start_i = 0;
      chk("idle_clear_no_start", busy_o, 0);
      chk_din("idle_clear_state", core_din_o, '0);

      do_write(7, WW'(8'h77));
      start_i = 1; cyc(); start_i = 0;
      clear_i = 1; cyc(); clear_i = 0;
      chk("launch_clear_drain", busy_o, 1);
      finish_core('1);
      chk("launch_clear_exit", busy_o, 0);
      chk_din("launch_clear_state", core_din_o, '0);

      finish_core('1);
      chk_din("stale_done_idle", core_din_o, '0);

      do_write(4, WW'(8'h44));
      start_i = 1; cyc(); start_i = 0; cyc();
      rst_n = 0;
      #1;
      chk("async_rst_busy", busy_o, 0);
      chk_din("async_rst_state", core_din_o, '0);
      @(negedge clk);
      rst_n = 1;
      #1;
      finish_core('1);
      chk("stale_done_busy", busy_o, 0);
      chk_din("stale_done_state", core_din_o, '0);

      do_write(NW - 1, {(WW/8){8'hF0}});
      do_write(NW - 1, {(WW/8){8'hF0}});
      do_read(NW - 1, rd, re, rv);
`ifdef KRONOS_KECCAK_ABSORB_XOR_EN
      chk("absorb_twice", 64'(rd), 0);
      absorb_bypass_i = 1;
      do_write(NW - 1, WW'(16'h1234));
      absorb_bypass_i = 0;
      do_read(NW - 1, rd, re, rv);
      chk("absorb_bypass", 64'(rd), 64'h1234);
`else
      chk("overwrite_twice", 64'(rd), 64'(WW'({8{8'hF0}})));
`endif

      cyc();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
